// File: rtl/sccb_slave.sv
// SCCB (I2C-like) register-file slave. The master's SIO_C/SIO_D are
// synchronized into the clk domain. Writes land in a 256-entry register file
// and are also reported on the wr_* strobe. Reads serialize the register file
// out onto an open-drain data line.
module sccb_slave #(
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sio_c,
  input  logic       sio_d_r,
  output logic       sio_d_w,
  output logic       en_sio_d_w,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
  } state_t;

  localparam logic [7:0] READ_ID = DEV_ID | 8'h01;

  state_t     state;
  logic [2:0] c_sync;
  logic [2:0] d_sync;
  logic       c_rise;
  logic       c_fall;
  logic       start_det;
  logic       stop_det;
  logic       d_now;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic [7:0] rd_byte;
  logic [6:0] tx_shift;
  logic [7:0] sub_addr;
  logic       read_mode;
  logic       read_ack;
  logic [7:0] regs [256];

  // Two synchronizer flops plus one history flop per line; reset to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= 3'b111;
      d_sync <= 3'b111;
    end else begin
      c_sync <= {c_sync[1:0], sio_c};
      d_sync <= {d_sync[1:0], sio_d_r};
    end
  end

  assign c_rise    = c_sync[1] & ~c_sync[2];
  assign c_fall    = ~c_sync[1] & c_sync[2];
  assign start_det = c_sync[1] & c_sync[2] & ~d_sync[1] & d_sync[2];
  assign stop_det  = c_sync[1] & c_sync[2] & d_sync[1] & ~d_sync[2];
  assign d_now     = d_sync[1];
  assign rx_byte   = {shift[6:0], d_now};
  assign rd_byte   = regs[sub_addr];

  // Protocol FSM; START/STOP outrank any clock edge seen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_shift   <= '0;
      sub_addr   <= '0;
      read_mode  <= 1'b0;
      read_ack   <= 1'b0;
      sio_d_w    <= 1'b0;
      en_sio_d_w <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        state      <= ID;
        bit_cnt    <= '0;
        en_sio_d_w <= 1'b0;
        sio_d_w    <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_det) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        en_sio_d_w <= 1'b0;
        sio_d_w    <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ID, ADDR, WDATA: begin
            if (c_rise && bit_cnt < 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7 && state == ADDR) begin
                sub_addr <= rx_byte;
              end
              if (bit_cnt == 4'd7 && state == WDATA) begin
                wr_en    <= 1'b1;
                wr_addr  <= sub_addr;
                wr_data  <= rx_byte;
                sub_addr <= sub_addr + 8'd1;
              end
            end else if (c_fall && bit_cnt == 4'd8) begin
              if (state != ID) begin
                state      <= (state == ADDR) ? ADDR_ACK : WDATA_ACK;
                en_sio_d_w <= 1'b1;
                sio_d_w    <= 1'b0;
              end else if (shift == DEV_ID || shift == READ_ID) begin
                state      <= ID_ACK;
                read_mode  <= (shift == READ_ID);
                en_sio_d_w <= 1'b1;
                sio_d_w    <= 1'b0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ID_ACK, ADDR_ACK, WDATA_ACK: begin
            if (c_fall) begin
              bit_cnt <= '0;
              if (state == ID_ACK && read_mode) begin
                state      <= RDATA;
                en_sio_d_w <= 1'b1;
                sio_d_w    <= rd_byte[7];
                tx_shift   <= rd_byte[6:0];
              end else begin
                state      <= (state == ID_ACK) ? ADDR : WDATA;
                en_sio_d_w <= 1'b0;
                sio_d_w    <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (c_fall) begin
              if (bit_cnt == 4'd7) begin
                state      <= RDATA_NA;
                en_sio_d_w <= 1'b0;
                sio_d_w    <= 1'b0;
                bit_cnt    <= 4'd8;
                read_ack   <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                sio_d_w  <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
          end
          RDATA_NA: begin
            if (c_rise && bit_cnt == 4'd8) begin
              bit_cnt  <= 4'd9;
              read_ack <= ~d_now;
              if (!d_now) begin
                sub_addr <= sub_addr + 8'd1;
              end
            end else if (c_fall && bit_cnt == 4'd9 && read_ack) begin
              state      <= RDATA;
              bit_cnt    <= '0;
              en_sio_d_w <= 1'b1;
              sio_d_w    <= rd_byte[7];
              tx_shift   <= rd_byte[6:0];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Register file, updated one cycle after the write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        regs[i] <= INIT_VAL;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule
